// File: rtl/cmp_serial_amisha.sv
// rtl/cmp_serial_amisha.sv - digit-serial magnitude/equality comparator, MSB digit first
// Optional feature macro: CMP_EARLY_EXIT_EN (finish on the first differing digit)
module cmp_serial_amisha #(
   parameter int WIDTH  = 8,
   parameter int DIGIT  = 2,
   parameter bit SIGNED = 1'b0
) (
   input  logic             clk_amisha,
   input  logic             rst_n_amisha,
   input  logic             start_amisha,
   input  logic [WIDTH-1:0] a_amisha,
   input  logic [WIDTH-1:0] b_amisha,
   output logic             busy_amisha,
   output logic             done_amisha,
   output logic             aeqb_amisha,
   output logic             agtb_amisha,
   output logic             altb_amisha
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = $clog2(N + 1);
   localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(SIGNED) << (WIDTH - 1);

   generate
      if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
         $error("cmp_serial_amisha: DIGIT must divide WIDTH and WIDTH must be >= 2");
      end
   endgenerate

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, b_sh_q;
   logic [CW-1:0]    cnt_q;
   logic             aeqb_q, agtb_q, altb_q, done_q;
   logic             accept, finish;
   logic [DIGIT-1:0] dig_a, dig_b;
   logic             digit_ne, decided;

   assign dig_a    = a_sh_q[WIDTH-1 -: DIGIT];
   assign dig_b    = b_sh_q[WIDTH-1 -: DIGIT];
   assign digit_ne = (dig_a != dig_b);
   assign decided  = agtb_q | altb_q;

   always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
      if (!rst_n_amisha) state_q <= S_IDLE;
      else               state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      finish  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_amisha) begin
               accept  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_q == CW'(1)) finish = 1'b1;
`ifdef CMP_EARLY_EXIT_EN
            if (digit_ne && !decided) finish = 1'b1;
`endif
            if (finish) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Signed mode flips each MSB at capture so an unsigned digit compare yields signed order.
   always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
      if (!rst_n_amisha) begin
         a_sh_q <= '0;
         b_sh_q <= '0;
         cnt_q  <= '0;
         aeqb_q <= 1'b0;
         agtb_q <= 1'b0;
         altb_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            a_sh_q <= a_amisha ^ SIGN_MASK;
            b_sh_q <= b_amisha ^ SIGN_MASK;
            cnt_q  <= CW'(N);
            aeqb_q <= 1'b0;
            agtb_q <= 1'b0;
            altb_q <= 1'b0;
         end else if (state_q == S_RUN) begin
            a_sh_q <= a_sh_q << DIGIT;
            b_sh_q <= b_sh_q << DIGIT;
            cnt_q  <= cnt_q - CW'(1);
            // First differing digit decides; the flags never move afterwards.
            if (digit_ne && !decided) begin
               agtb_q <= (dig_a > dig_b);
               altb_q <= (dig_a < dig_b);
            end
            if (finish) begin
               done_q <= 1'b1;
               if (!decided && !digit_ne) aeqb_q <= 1'b1;
            end
         end
      end
   end

   assign busy_amisha = (state_q == S_RUN);
   assign done_amisha = done_q;
   assign aeqb_amisha = aeqb_q & ~busy_amisha;
   assign agtb_amisha = agtb_q & ~busy_amisha;
   assign altb_amisha = altb_q & ~busy_amisha;

endmodule

// File: tb/tb_cmp_serial_amisha.sv
// tb/tb_cmp_serial_amisha.sv - directed table-driven bench for cmp_serial_amisha
module tb_cmp_serial_amisha;
   localparam int NLAT = 4;

   typedef struct {
      int          sel;
      logic [15:0] a;
      logic [15:0] b;
      logic        eq;
      logic        gt;
      logic        lt;
      int          lat_e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        st [0:2];
   logic [15:0] ai [0:2];
   logic [15:0] bi [0:2];
   logic [4:0]  outv [0:2];
   logic        busy0, done0, eq0, gt0, lt0;
   logic        busy1, done1, eq1, gt1, lt1;
   logic        busy2, done2, eq2, gt2, lt2;

   int total = 0;
   int bad = 0;
   vec_t vt [0:15];

   always #5 clk = ~clk;

   cmp_serial_amisha #(.WIDTH(8), .DIGIT(2), .SIGNED(1'b0)) dut_u (
      .clk_amisha(clk), .rst_n_amisha(rst_n), .start_amisha(st[0]),
      .a_amisha(ai[0][7:0]), .b_amisha(bi[0][7:0]),
      .busy_amisha(busy0), .done_amisha(done0),
      .aeqb_amisha(eq0), .agtb_amisha(gt0), .altb_amisha(lt0));

   cmp_serial_amisha #(.WIDTH(8), .DIGIT(2), .SIGNED(1'b1)) dut_s (
      .clk_amisha(clk), .rst_n_amisha(rst_n), .start_amisha(st[1]),
      .a_amisha(ai[1][7:0]), .b_amisha(bi[1][7:0]),
      .busy_amisha(busy1), .done_amisha(done1),
      .aeqb_amisha(eq1), .agtb_amisha(gt1), .altb_amisha(lt1));

   cmp_serial_amisha #(.WIDTH(16), .DIGIT(4), .SIGNED(1'b0)) dut_w (
      .clk_amisha(clk), .rst_n_amisha(rst_n), .start_amisha(st[2]),
      .a_amisha(ai[2]), .b_amisha(bi[2]),
      .busy_amisha(busy2), .done_amisha(done2),
      .aeqb_amisha(eq2), .agtb_amisha(gt2), .altb_amisha(lt2));

   assign outv[0] = {busy0, done0, eq0, gt0, lt0};
   assign outv[1] = {busy1, done1, eq1, gt1, lt1};
   assign outv[2] = {busy2, done2, eq2, gt2, lt2};

   task automatic check(input string name, input int idx, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, req);
      end
   endtask

   function automatic int exp_lat(input vec_t v);
`ifdef CMP_EARLY_EXIT_EN
      return v.lat_e;
`else
      return NLAT;
`endif
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      int k;
      bit seen;
      k = 0;
      seen = 1'b0;
      @(negedge clk);
      st[v.sel] = 1'b1; ai[v.sel] = v.a; bi[v.sel] = v.b;
      @(posedge clk);
      @(negedge clk);
      st[v.sel] = 1'b0; ai[v.sel] = 16'($urandom); bi[v.sel] = 16'($urandom);
      check("busy_flags_zero", idx, int'(outv[v.sel]), 5'b10000);
      while (!seen && k < 20) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (outv[v.sel][3]) seen = 1'b1;
      end
      check("latency", idx, k, exp_lat(v));
      check("done_result", idx, int'(outv[v.sel]), int'({2'b01, v.eq, v.gt, v.lt}));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_hold", idx, int'(outv[v.sel]), int'({2'b00, v.eq, v.gt, v.lt}));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{0, 16'h00A5, 16'h00A5, 1'b1, 1'b0, 1'b0, 4};
      vt[1]  = '{0, 16'h0080, 16'h007F, 1'b0, 1'b1, 1'b0, 1};
      vt[2]  = '{0, 16'h0034, 16'h0035, 1'b0, 1'b0, 1'b1, 4};
      vt[3]  = '{0, 16'h0000, 16'h00FF, 1'b0, 1'b0, 1'b1, 1};
      vt[4]  = '{0, 16'h00FF, 16'h00FE, 1'b0, 1'b1, 1'b0, 4};
      vt[5]  = '{0, 16'h0064, 16'h006C, 1'b0, 1'b0, 1'b1, 3};
      vt[6]  = '{0, 16'h00C0, 16'h0080, 1'b0, 1'b1, 1'b0, 1};
      vt[7]  = '{0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 4};
      vt[8]  = '{1, 16'h0080, 16'h007F, 1'b0, 1'b0, 1'b1, 1};
      vt[9]  = '{1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, 1};
      vt[10] = '{1, 16'h00FE, 16'h00FF, 1'b0, 1'b0, 1'b1, 4};
      vt[11] = '{1, 16'h007F, 16'h0080, 1'b0, 1'b1, 1'b0, 1};
      vt[12] = '{2, 16'h1234, 16'h1233, 1'b0, 1'b1, 1'b0, 4};
      vt[13] = '{2, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1};
      vt[14] = '{2, 16'hABCD, 16'hABCD, 1'b1, 1'b0, 1'b0, 4};
      vt[15] = '{2, 16'h1200, 16'h1300, 1'b0, 1'b0, 1'b1, 2};

      for (int s = 0; s < 3; s++) begin
         st[s] = 1'b0; ai[s] = '0; bi[s] = '0;
      end

      // Reset state
      @(negedge clk);
      for (int s = 0; s < 3; s++) check("reset_outputs", s, int'(outv[s]), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) run_vec(vt[i], i);

      // Start while busy is ignored, inputs change mid-run, then start in the done cycle
      @(negedge clk);
      st[0] = 1'b1; ai[0] = 16'h0034; bi[0] = 16'h0035;
      @(posedge clk);
      @(negedge clk);
      st[0] = 1'b0;
      check("seq_busy_e0", 100, int'(outv[0]), 5'b10000);
      @(posedge clk);
      @(negedge clk);
      st[0] = 1'b1; ai[0] = 16'h0000; bi[0] = 16'h0000;
      @(posedge clk);
      @(negedge clk);
      st[0] = 1'b0; ai[0] = 16'h00FF; bi[0] = 16'h0000;
      check("seq_busy_e2", 101, int'(outv[0]), 5'b10000);
      @(posedge clk);
      @(negedge clk);
      check("seq_busy_e3", 102, int'(outv[0]), 5'b10000);
      @(posedge clk);
      @(negedge clk);
      check("seq_done_lt", 103, int'(outv[0]), 5'b01001);
      st[0] = 1'b1; ai[0] = 16'h0001; bi[0] = 16'h0000;
      @(posedge clk);
      @(negedge clk);
      st[0] = 1'b0;
      check("seq_b2b_accept", 104, int'(outv[0]), 5'b10000);
      begin
         int k;
         bit seen;
         k = 0;
         seen = 1'b0;
         while (!seen && k < 20) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (done0) seen = 1'b1;
         end
         check("seq_b2b_latency", 105, k, NLAT);
         check("seq_b2b_result", 106, int'(outv[0]), 5'b01010);
      end

      // Asynchronous reset mid-compare
      @(negedge clk);
      st[0] = 1'b1; ai[0] = 16'h0034; bi[0] = 16'h0035;
      @(posedge clk);
      @(negedge clk);
      st[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_mid_outputs", 107, int'(outv[0]), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_no_done", 108 + i, int'(outv[0]), 0);
      end
      rst_n = 1'b1;
      run_vec('{0, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 4}, 111);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cmp_serial_amisha.md
Name: cmp_serial_amisha

Overview:
- Parametrised, multi-cycle magnitude/equality comparator. Generalises the 2-bit gate-level equality check to WIDTH-bit operands, with equal, greater-than and less-than results and optional signed mode.
- Compares DIGIT bits per clock, MSB digit first, under a start/busy/done handshake.
- Sits beside datapath blocks that need a low-area compare and can tolerate multi-cycle latency.

Parameters:
- WIDTH, 8, operand width in bits; WIDTH >= 2.
- DIGIT, 2, bits compared per cycle. Must divide WIDTH exactly; otherwise elaboration fails via a generate-time check.
- SIGNED, 0, 1 = operands are two's complement, 0 = unsigned.

Ports:
- clk_amisha  in  1  clock, rising edge.
- rst_n_amisha  in  1  reset, asynchronous, active-low.
- start_amisha  in  1  request; sampled only in IDLE.
- a_amisha  in  WIDTH  operand A; captured on the accepting edge.
- b_amisha  in  WIDTH  operand B; captured on the accepting edge.
- busy_amisha  out  1  high while a compare is in progress.
- done_amisha  out  1  one-cycle pulse; results valid.
- aeqb_amisha  out  1  A == B.
- agtb_amisha  out  1  A > B.
- altb_amisha  out  1  A < B.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Any time rst_n_amisha is low: state=IDLE and all outputs 0.
  - Internal shift registers, digit counter and result flags are cleared.
  - Reset mid-compare aborts with no done pulse.
- Let N = WIDTH/DIGIT.
- FSM states: IDLE, RUN.
- IDLE:
  - start_amisha=1 at edge E0 → latch a/b into shift registers, counter=N, clear all three result flags, go to RUN, busy=1.
  - If SIGNED=1, the MSB of each latched operand is inverted at capture, so the signed order maps onto unsigned order.
- RUN, each edge Ej (j = 1..N): compare the top DIGIT bits of A-shift vs B-shift, unsigned.
  - Digits equal: shift both registers left by DIGIT; counter decrements.
  - Digits differ: set agtb or altb accordingly; this is the decided result.
  - Termination without early exit: after edge EN → go to IDLE, busy=0, done=1 for exactly one cycle.
  - If no differing digit was found, set aeqb=1 at EN.
- Once a result is decided, later digits must not change the flags.
- After done, exactly one of aeqb/agtb/altb is 1. The flags hold until the next accepted start, which clears them.
- Flags read 0 while busy=1.
- start_amisha while busy=1 is ignored: no re-capture and no effect on the result.
- start_amisha high in the cycle done=1 (FSM in IDLE) is accepted. Back-to-back compares need no idle gap.
- Operand inputs may change freely while busy; only the captured copies are used.
- Latency without early exit: done rises after edge EN, exactly N cycles after the accepting edge, independent of the data.

Optional Feature:
- Macro: CMP_EARLY_EXIT_EN.
- Defined:
  - On the first differing digit at edge Ej, the FSM returns to IDLE at Ej: busy=0, done pulses, flags are valid.
  - Latency is j cycles (1..N). Equal operands still take N cycles.
- Undefined:
  - The FSM always runs all N digits. Latency is fixed at N.
  - Flags stay frozen after the decision, and done pulses after EN.

Test Plan (WIDTH=8, DIGIT=2, N=4 unless noted):
- a=0xA5, b=0xA5, start at E0 → busy high E0..E4; done pulse after E4; aeqb=1, agtb=0, altb=0; holds for 3 idle cycles.
- SIGNED=0, a=0x80, b=0x7F → agtb=1. Done after E1 with CMP_EARLY_EXIT_EN; after E4 without.
- SIGNED=1, a=0x80 (-128), b=0x7F (127) → altb=1, aeqb=0, agtb=0. Same latencies as the previous case.
- a=0x34, b=0x35 → altb=1 after E4 in both builds. Also WIDTH=16, DIGIT=4, a=0x1234, b=0x1233 → agtb=1 after E4.
- Pulse start again at E2 with a=b=0; change a_amisha/b_amisha mid-run → ignored, original 0x34 vs 0x35 result unaffected. Then assert start in the done cycle with a=0x01, b=0x00 → accepted; agtb=1 after 4 further cycles (no CMP_EARLY_EXIT_EN).
- Drop rst_n_amisha asynchronously at mid-cycle after E2 → busy, done and all flags 0 immediately; no done pulse. After release, a new start compares correctly.
